csa_seq_mult: RTL
=================

Name: csa_seq_mult

Overview:
Parametrised iterative multiplier. It accumulates one partial product per cycle in carry-save form (sum/carry vectors through a W-bit 3:2 compressor row), then resolves the result with a single carry-propagate add. It generalises the fixed 4-bit CSA stage to any WIDTH, adds signed/unsigned mode, and adds a valid/ready handshake on both sides. It sits between the UART/SPI operand front-end and the result serialiser.

Parameters:
WIDTH, 8, operand width in bits; legal values are 2 to 32. The product is 2*WIDTH bits.

Ports:
clk  in  1  system clock; all state changes on the rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept operands
in_signed  in  1  1 = two's-complement operands; 0 = unsigned; sampled at accept
in_a  in  WIDTH  multiplicand
in_b  in  WIDTH  multiplier
out_valid  out  1  product valid
out_ready  in  1  consumer accepts product
out_p  out  2*WIDTH  product
busy  out  1  high in CALC or RESOLVE

Behaviour:
- One clock, clk. rst_n is asynchronous and active-low; assertion clears all state at once, and deassertion is used synchronously.
- Reset values:
  - state = IDLE
  - in_ready = 1
  - out_valid = 0
  - out_p = 0
  - busy = 0
  - internal sum/carry/counter/sign registers all 0
- States: IDLE, CALC, RESOLVE, DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). An accept is in_valid && in_ready on a rising edge.
- On accept:
  - Latch ma = |in_a| and mb = |in_b| as WIDTH-bit unsigned magnitudes when in_signed=1; otherwise latch the raw values.
  - Latch neg = in_signed & (in_a[MSB] ^ in_b[MSB]).
  - Clear sum/carry (2*WIDTH bits each), set cnt = 0, go to CALC.
- Most-negative operand: |-2^(WIDTH-1)| = 2^(WIDTH-1) fits in WIDTH unsigned bits. No overflow path exists.
- CALC, each cycle:
  - pp = mb[cnt] ? (ma << cnt) : 0.
  - {carry, sum} <= csa(sum, carry<<1, pp), truncated to 2*WIDTH bits.
  - cnt increments. When cnt == WIDTH-1, go to RESOLVE.
  - CALC lasts exactly WIDTH cycles. There is no early termination, even for zero operands.
- RESOLVE, one cycle:
  - mag = sum + (carry<<1), mod 2^(2*WIDTH).
  - out_p <= neg ? -mag : mag.
  - out_valid <= 1, go to DONE.
  - -0 = 0, so the result is never a negative zero.
- Latency: with the accept at edge T, out_valid rises after edge T+WIDTH+1. For WIDTH=8 that is 9 cycles.
- DONE:
  - out_p and out_valid are held stable until out_ready=1.
  - On the out_ready edge, out_valid drops.
  - If in_valid is also high on that edge, the new operands are accepted in the same edge and the block goes straight to CALC (zero-bubble back-to-back). Otherwise it goes to IDLE.
- out_ready outside DONE is ignored.
- in_valid outside IDLE/DONE is ignored. Operands are not required to be held after the accept.
- in_a, in_b and in_signed changing during CALC/RESOLVE have no effect.
- Reset asserted mid-CALC or mid-DONE: the in-flight result is discarded, no out_valid pulse occurs, and the block returns to the reset values immediately.
- busy = (state==CALC || state==RESOLVE).

Decomposition:
- Package mult_pkg:
  - state enum mult_state_t {IDLE, CALC, RESOLVE, DONE}
  - localparam function for counter width, $clog2(WIDTH)
- One combinational sub-module, csa_row #(N): bitwise 3:2 compressor.
  - Inputs x, y, z; outputs s = x^y^z and c = maj(x,y,z).
  - Instantiated once with N = 2*WIDTH.
- FSM, magnitude/negate logic and the final adder stay in csa_seq_mult.

Test Plan:
- WIDTH=8, unsigned, 255*255, out_ready=1 -> out_p=16'hFE01. out_valid rises exactly 9 cycles after accept and is high for 1 cycle.
- WIDTH=8, signed:
  - -128*-128 -> 16'h4000
  - -3*5 -> 16'hFFF1
  - 127*-1 -> 16'hFF81
  - 0*-7 -> 16'h0000
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_p and out_valid stable and in_ready=0. Raise out_ready with in_valid=1 holding operands 3*4 -> same-edge accept, next out_p=16'h000C, no IDLE cycle.
- Reset mid-op: assert rst_n=0 asynchronously, between clock edges, at cnt=4 of 200*200 -> outputs take reset values immediately, with no out_valid ever seen. A following 2*3 -> out_p=6.
- Stimulus changes during CALC: change in_a/in_b/in_signed every cycle during CALC -> result is unaffected. Also drive in_valid high during CALC -> ignored, in_ready=0.
- WIDTH=4 instance:
  - unsigned 15*15 -> 8'hE1
  - signed -8*7 -> 8'hC8
  - latency 5 cycles.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types for the carry-save sequential multiplier.
package mult_pkg;

  typedef enum logic [1:0] {IDLE, CALC, RESOLVE, DONE} mult_state_t;

  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/csa_row.sv
// Bitwise 3:2 compressor row: s = x^y^z, c = majority(x,y,z).
module csa_row #(
  parameter int N = 8
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic [N-1:0] z,
  output logic [N-1:0] s,
  output logic [N-1:0] c
);

  assign s = x ^ y ^ z;
  assign c = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/csa_seq_mult.sv
// Iterative multiplier: one partial product per cycle into carry-save
// sum/carry registers, then a single carry-propagate add and sign fix.
module csa_seq_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  mult_state_t state, state_nxt;

  logic [WIDTH-1:0] ma, mb;
  logic             neg;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    sum, carry, pp, sum_nxt, carry_nxt, mag;
  logic             accept;

  assign in_ready = (state == IDLE) || (state == DONE && out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state == CALC) || (state == RESOLVE);

  assign pp  = mb[cnt] ? (PW'(ma) << cnt) : '0;
  assign mag = sum + (carry << 1);

  csa_row #(.N(PW)) u_csa_row (
    .x(sum),
    .y(carry << 1),
    .z(pp),
    .s(sum_nxt),
    .c(carry_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (cnt == CNT_LAST) state_nxt = RESOLVE;
      RESOLVE: state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = accept ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Magnitudes are taken at accept so the array only ever adds unsigned terms.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma        <= '0;
      mb        <= '0;
      neg       <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      carry     <= '0;
      out_p     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        ma    <= (in_signed && in_a[WIDTH-1]) ? -in_a : in_a;
        mb    <= (in_signed && in_b[WIDTH-1]) ? -in_b : in_b;
        neg   <= in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
        cnt   <= '0;
        sum   <= '0;
        carry <= '0;
      end else if (state == CALC) begin
        sum   <= sum_nxt;
        carry <= carry_nxt;
        cnt   <= cnt + CW'(1);
      end

      if (state == RESOLVE) begin
        out_p     <= neg ? -mag : mag;
        out_valid <= 1'b1;
      end else if (state == DONE && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
